// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types used by the cache-management-operation handler.
// The CMO opcode is a one-hot packed struct, with the fence operation in the MSB.
package hpdcache_pkg;

    typedef struct packed {
        logic is_fence;
        logic is_inval_by_nline;
        logic is_inval_by_set;
        logic is_inval_all;
        logic is_flush_by_nline;
        logic is_flush_all;
    } hpdcache_cmoh_op_t;

    function automatic logic cmoh_op_is_nline(hpdcache_cmoh_op_t op);
        return op.is_inval_by_nline | op.is_flush_by_nline;
    endfunction

    // Operations whose directory walk steps through every set.
    function automatic logic cmoh_op_is_sweep(hpdcache_cmoh_op_t op);
        return op.is_inval_all | op.is_flush_all;
    endfunction

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Priority encoder that keeps only the lowest set bit of the input vector.
// The result is one-hot, or all zeros when no input bit is set.
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        val_o   = '0;
        for (int i = 0; i < N; i++) begin
            val_o[i] = val_i[i] & ~w_found;
            w_found  = w_found | val_i[i];
        end
    end

endmodule

// File: rtl/hpdcache_cmoh.sv
// Cache-management-operation handler. It executes fences and invalidations by line, by set, or for all sets.
// It also executes flush-by-line and flush-all, which write back dirty lines before invalidating them.
module hpdcache_cmoh
    import hpdcache_pkg::*;
#(
    parameter int unsigned SETS         = 64,
    parameter int unsigned WAYS         = 4,
    parameter int unsigned ADDR_WIDTH   = 49,
    parameter int unsigned OFFSET_WIDTH = 6,
    localparam int unsigned SET_W       = $clog2(SETS),
    localparam int unsigned TAG_W       = ADDR_WIDTH - OFFSET_WIDTH - SET_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wbuf_empty_i,
    input  logic                  mshr_empty_i,
    input  logic                  rtab_empty_i,
    input  logic                  ctrl_empty_i,
    input  logic                  flush_empty_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  hpdcache_cmoh_op_t     req_op_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WAYS-1:0]       req_way_i,
    output logic                  req_wait_o,
    output logic                  rsp_valid_o,
    output logic                  wbuf_flush_all_o,
    output logic                  dir_check_o,
    output logic [SET_W-1:0]      dir_check_set_o,
    output logic [TAG_W-1:0]      dir_check_tag_o,
    input  logic [WAYS-1:0]       dir_check_hit_way_i,
    input  logic [WAYS-1:0]       dir_check_dirty_i,
    output logic                  dir_inval_o,
    input  logic                  dir_inval_ready_i,
    output logic [SET_W-1:0]      dir_inval_set_o,
    output logic [WAYS-1:0]       dir_inval_way_o,
    output logic                  flush_valid_o,
    input  logic                  flush_ready_i,
    output logic [SET_W-1:0]      flush_set_o,
    output logic [WAYS-1:0]       flush_way_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FENCE_WAIT, ST_DRAIN, ST_CHECK,
        ST_EVAL, ST_FLUSH, ST_INVAL, ST_FLUSH_WAIT
    } state_e;

    state_e            r_state, w_state_next, w_req_first, w_lat_first;
    hpdcache_cmoh_op_t r_op;
    logic [SET_W-1:0]  r_set, r_set_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic [WAYS-1:0]   r_way, r_pend, r_inval_way;
    logic              r_rsp;

    logic [SET_W-1:0]        w_req_set;
    logic [TAG_W-1:0]        w_req_tag;
    logic [OFFSET_WIDTH-1:0] w_unused_offset;
    logic                    w_req_legal, w_fence_req, w_op_req, w_fence_clear, w_drained;
    logic                    w_is_nline, w_is_sweep, w_last_set, w_done, w_strobe_en;
    logic [WAYS-1:0]         w_pend_eval, w_flush_sel, w_pend_left;

    assign w_req_set       = req_addr_i[OFFSET_WIDTH +: SET_W];
    assign w_req_tag       = req_addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign w_unused_offset = req_addr_i[OFFSET_WIDTH-1:0];

    assign w_req_legal   = req_valid_i && (r_state == ST_IDLE) && $onehot(req_op_i);
    assign w_fence_req   = w_req_legal && req_op_i.is_fence;
    assign w_op_req      = w_req_legal && !req_op_i.is_fence;
    assign w_fence_clear = wbuf_empty_i && rtab_empty_i;
    assign w_drained     = mshr_empty_i && rtab_empty_i && ctrl_empty_i;
    assign w_req_first   = (req_op_i.is_inval_by_set || req_op_i.is_inval_all) ? ST_INVAL : ST_CHECK;
    assign w_lat_first   = (r_op.is_inval_by_set || r_op.is_inval_all) ? ST_INVAL : ST_CHECK;
    assign w_is_nline    = cmoh_op_is_nline(r_op);
    assign w_is_sweep    = cmoh_op_is_sweep(r_op);
    assign w_last_set    = (r_set_cnt == SET_W'(SETS - 1));
    assign w_pend_eval   = r_op.is_flush_by_nline ? (dir_check_dirty_i & dir_check_hit_way_i) :
                           r_op.is_flush_all      ? dir_check_dirty_i : '0;
    assign w_pend_left   = r_pend & ~w_flush_sel;

    hpdcache_prio_1hot_encoder #(.N(WAYS)) u_flush_sel (
        .val_i (r_pend),
        .val_o (w_flush_sel)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_rsp   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rsp   <= w_done;
        end
    end

    // NOTE: every variable gets a default before the case, so no latch can be inferred.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fence_req) begin
                    if (w_fence_clear) w_done = 1'b1;
                    else               w_state_next = ST_FENCE_WAIT;
                end else if (w_op_req) begin
                    w_state_next = w_drained ? w_req_first : ST_DRAIN;
                end
            end
            ST_FENCE_WAIT: if (w_fence_clear) begin
                w_state_next = ST_IDLE;
                w_done       = 1'b1;
            end
            ST_DRAIN: if (w_drained) w_state_next = w_lat_first;
            ST_CHECK: w_state_next = ST_EVAL;
            ST_EVAL: begin
                if (w_is_nline && (dir_check_hit_way_i == '0)) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end else if (w_pend_eval != '0) begin
                    w_state_next = ST_FLUSH;
                end else begin
                    w_state_next = ST_INVAL;
                end
            end
            ST_FLUSH: if (flush_ready_i && (w_pend_left == '0)) w_state_next = ST_INVAL;
            ST_INVAL: if (dir_inval_ready_i) begin
                if (w_is_sweep && !w_last_set) begin
                    w_state_next = r_op.is_inval_all ? ST_INVAL : ST_CHECK;
                end else if (r_op.is_flush_all || r_op.is_flush_by_nline) begin
                    w_state_next = ST_FLUSH_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            ST_FLUSH_WAIT: if (flush_empty_i) begin
                w_state_next = ST_IDLE;
                w_done       = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: request payload registers are not reset; they are always written before any state reads them.
    always_ff @(posedge clk_i) begin
        if (w_op_req) begin
            r_op  <= req_op_i;
            r_set <= w_req_set;
            r_tag <= w_req_tag;
            r_way <= req_way_i;
        end
        if (r_state == ST_EVAL) begin
            r_inval_way <= w_is_nline ? dir_check_hit_way_i : '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_set_cnt <= '0;
            r_pend    <= '0;
        end else begin
            if (w_op_req) r_set_cnt <= '0;
            else if ((r_state == ST_INVAL) && dir_inval_ready_i && w_is_sweep) r_set_cnt <= r_set_cnt + 1'b1;

            if (r_state == ST_EVAL) r_pend <= w_pend_eval;
            else if ((r_state == ST_FLUSH) && flush_ready_i) r_pend <= w_pend_left;
        end
    end

    // Strobes are forced low while reset is held, even though the state register only clears at the edge.
    assign w_strobe_en = !rst_i;

    always_comb begin
        req_ready_o      = (r_state == ST_IDLE);
        req_wait_o       = (r_state == ST_FENCE_WAIT) || (r_state == ST_DRAIN);
        rsp_valid_o      = r_rsp;
        wbuf_flush_all_o = w_strobe_en && rtab_empty_i && (w_fence_req || (r_state == ST_FENCE_WAIT));
        dir_check_o      = w_strobe_en && (r_state == ST_CHECK);
        dir_check_set_o  = r_op.is_flush_all ? r_set_cnt : r_set;
        dir_check_tag_o  = r_tag;
        dir_inval_o      = w_strobe_en && (r_state == ST_INVAL);
        dir_inval_set_o  = w_is_sweep ? r_set_cnt : r_set;
        dir_inval_way_o  = r_op.is_inval_by_set ? r_way :
                           r_op.is_inval_all    ? '1 : r_inval_way;
        flush_valid_o    = w_strobe_en && (r_state == ST_FLUSH);
        flush_set_o      = r_op.is_flush_all ? r_set_cnt : r_set;
        flush_way_o      = w_flush_sel;
    end

endmodule

// File: tb/tb_hpdcache_cmoh.sv
// Directed testbench for hpdcache_cmoh with SETS=8 and WAYS=4.
// A small directory model returns hit/dirty masks for the set most recently looked up.
module tb_hpdcache_cmoh;
    import hpdcache_pkg::*;

    localparam int unsigned SETS = 8;
    localparam int unsigned WAYS = 4;
    localparam int unsigned AW   = 49;
    localparam int unsigned OW   = 6;
    localparam int unsigned SW   = 3;
    localparam int unsigned TW   = AW - OW - SW;

    localparam hpdcache_cmoh_op_t OP_FENCE     = 6'b100000;
    localparam hpdcache_cmoh_op_t OP_INV_NLINE = 6'b010000;
    localparam hpdcache_cmoh_op_t OP_INV_SET   = 6'b001000;
    localparam hpdcache_cmoh_op_t OP_INV_ALL   = 6'b000100;
    localparam hpdcache_cmoh_op_t OP_FL_NLINE  = 6'b000010;
    localparam hpdcache_cmoh_op_t OP_FL_ALL    = 6'b000001;

    logic clk = 1'b0;
    logic rst_i;
    logic wbuf_empty_i, mshr_empty_i, rtab_empty_i, ctrl_empty_i, flush_empty_i;
    logic req_valid_i, req_ready_o, req_wait_o, rsp_valid_o, wbuf_flush_all_o;
    hpdcache_cmoh_op_t req_op_i;
    logic [AW-1:0] req_addr_i;
    logic [WAYS-1:0] req_way_i;
    logic dir_check_o, dir_inval_o, dir_inval_ready_i, flush_valid_o, flush_ready_i;
    logic [SW-1:0] dir_check_set_o, dir_inval_set_o, flush_set_o;
    logic [TW-1:0] dir_check_tag_o;
    logic [WAYS-1:0] dir_check_hit_way_i, dir_check_dirty_i, dir_inval_way_o, flush_way_o;

    logic [WAYS-1:0] tb_hit   [SETS];
    logic [WAYS-1:0] tb_dirty [SETS];
    logic [SW-1:0]   tb_last_set = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int rsp_cnt = 0;
    int chk_cnt = 0;
    logic [SW-1:0]   inv_set_q[$];
    logic [WAYS-1:0] inv_way_q[$];
    int              inv_cyc_q[$];
    logic [SW-1:0]   fl_set_q[$];
    logic [WAYS-1:0] fl_way_q[$];

    always #5 clk = ~clk;

    hpdcache_cmoh #(
        .SETS(SETS), .WAYS(WAYS), .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .wbuf_empty_i        (wbuf_empty_i),
        .mshr_empty_i        (mshr_empty_i),
        .rtab_empty_i        (rtab_empty_i),
        .ctrl_empty_i        (ctrl_empty_i),
        .flush_empty_i       (flush_empty_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_op_i            (req_op_i),
        .req_addr_i          (req_addr_i),
        .req_way_i           (req_way_i),
        .req_wait_o          (req_wait_o),
        .rsp_valid_o         (rsp_valid_o),
        .wbuf_flush_all_o    (wbuf_flush_all_o),
        .dir_check_o         (dir_check_o),
        .dir_check_set_o     (dir_check_set_o),
        .dir_check_tag_o     (dir_check_tag_o),
        .dir_check_hit_way_i (dir_check_hit_way_i),
        .dir_check_dirty_i   (dir_check_dirty_i),
        .dir_inval_o         (dir_inval_o),
        .dir_inval_ready_i   (dir_inval_ready_i),
        .dir_inval_set_o     (dir_inval_set_o),
        .dir_inval_way_o     (dir_inval_way_o),
        .flush_valid_o       (flush_valid_o),
        .flush_ready_i       (flush_ready_i),
        .flush_set_o         (flush_set_o),
        .flush_way_o         (flush_way_o)
    );

    always @(posedge clk) if (dir_check_o) tb_last_set <= dir_check_set_o;
    assign dir_check_hit_way_i = tb_hit[tb_last_set];
    assign dir_check_dirty_i   = tb_dirty[tb_last_set];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_i) begin
            if (dir_inval_o && dir_inval_ready_i) begin
                inv_set_q.push_back(dir_inval_set_o);
                inv_way_q.push_back(dir_inval_way_o);
                inv_cyc_q.push_back(cyc);
            end
            if (flush_valid_o && flush_ready_i) begin
                fl_set_q.push_back(flush_set_o);
                fl_way_q.push_back(flush_way_o);
            end
            if (rsp_valid_o) rsp_cnt = rsp_cnt + 1;
            if (dir_check_o) chk_cnt = chk_cnt + 1;
        end
    end

    function automatic logic [AW-1:0] mk_addr(input logic [TW-1:0] tag, input logic [SW-1:0] set);
        return {tag, set, 6'h2a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b1;
        req_op_i = OP_FENCE;
        @(negedge clk);
        n_checks++;
        if ({wbuf_flush_all_o, dir_check_o, dir_inval_o, flush_valid_o, rsp_valid_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {wbuf_flush_all_o, dir_check_o, dir_inval_o, flush_valid_o, rsp_valid_o});
        end
        tick();
        rst_i = 1'b0;
        req_valid_i = 1'b0;
        req_op_i = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({req_ready_o, req_wait_o, wbuf_flush_all_o, dir_check_o, dir_inval_o, flush_valid_o, rsp_valid_o} !== 7'b1000000) begin
                n_fail++;
                $display("FAIL post_reset_%0d: got %b expected 1000000", i,
                         {req_ready_o, req_wait_o, wbuf_flush_all_o, dir_check_o, dir_inval_o, flush_valid_o, rsp_valid_o});
            end
            tick();
        end
    endtask

    task automatic test_fence_immediate();
        req_valid_i = 1'b1;
        req_op_i = OP_FENCE;
        @(negedge clk);
        n_checks++;
        if ({req_ready_o, wbuf_flush_all_o, rsp_valid_o} !== 3'b110) begin
            n_fail++;
            $display("FAIL fence_accept: got %b expected 110", {req_ready_o, wbuf_flush_all_o, rsp_valid_o});
        end
        tick();
        req_valid_i = 1'b0;
        req_op_i = '0;
        @(negedge clk);
        n_checks++;
        if ({req_ready_o, req_wait_o, rsp_valid_o} !== 3'b101) begin
            n_fail++;
            $display("FAIL fence_rsp: got %b expected 101", {req_ready_o, req_wait_o, rsp_valid_o});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fence_rsp_pulse: got %b expected 0", rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_fence_wait();
        logic [2:0] exp;
        for (int i = 0; i <= 6; i++) begin
            req_valid_i  = (i == 0);
            req_op_i     = (i == 0) ? OP_FENCE : '0;
            wbuf_empty_i = (i >= 5);
            rtab_empty_i = (i != 2);
            exp = {(i <= 5) && (i != 2), (i >= 1) && (i <= 5), (i == 6)};
            @(negedge clk);
            n_checks++;
            if ({wbuf_flush_all_o, req_wait_o, rsp_valid_o} !== exp) begin
                n_fail++;
                $display("FAIL fence_wait_c%0d: got flush_all/wait/rsp %b expected %b", i,
                         {wbuf_flush_all_o, req_wait_o, rsp_valid_o}, exp);
            end
            tick();
        end
        wbuf_empty_i = 1'b1;
        rtab_empty_i = 1'b1;
    endtask

    task automatic test_inval_nline_drain();
        logic [3:0] exp;
        logic [TW-1:0] tag;
        tag = 40'h12_3456_789a;
        tb_hit[5] = 4'b0100;
        for (int i = 0; i <= 8; i++) begin
            req_valid_i  = (i == 0);
            req_op_i     = OP_INV_NLINE;
            req_addr_i   = mk_addr(tag, 3'd5);
            mshr_empty_i = (i >= 3);
            exp = {(i >= 1) && (i <= 3), i == 4, i == 6, i == 7};
            @(negedge clk);
            n_checks++;
            if ({req_wait_o, dir_check_o, dir_inval_o, rsp_valid_o} !== exp) begin
                n_fail++;
                $display("FAIL nline_drain_c%0d: got wait/chk/inv/rsp %b expected %b", i,
                         {req_wait_o, dir_check_o, dir_inval_o, rsp_valid_o}, exp);
            end
            if (i == 4) begin
                n_checks++;
                if (dir_check_set_o !== 3'd5 || dir_check_tag_o !== tag) begin
                    n_fail++;
                    $display("FAIL nline_check_addr: got set %0d tag %h expected set 5 tag %h",
                             dir_check_set_o, dir_check_tag_o, tag);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (dir_inval_set_o !== 3'd5 || dir_inval_way_o !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL nline_inval: got set %0d way %b expected set 5 way 0100",
                             dir_inval_set_o, dir_inval_way_o);
                end
            end
            tick();
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
        tb_hit[5] = '0;
    endtask

    task automatic test_nline_miss();
        int inv_base;
        logic [1:0] exp;
        inv_base = inv_set_q.size();
        for (int i = 0; i <= 4; i++) begin
            req_valid_i = (i == 0);
            req_op_i    = OP_INV_NLINE;
            req_addr_i  = mk_addr(40'h1, 3'd1);
            exp = {1'b0, i == 3};
            @(negedge clk);
            n_checks++;
            if ({dir_inval_o, rsp_valid_o} !== exp) begin
                n_fail++;
                $display("FAIL nline_miss_c%0d: got inv/rsp %b expected %b", i, {dir_inval_o, rsp_valid_o}, exp);
            end
            tick();
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
        n_checks++;
        if (inv_set_q.size() != inv_base) begin
            n_fail++;
            $display("FAIL nline_miss_no_inval: got %0d invals expected 0", inv_set_q.size() - inv_base);
        end
    endtask

    task automatic test_inval_by_set();
        logic [2:0] exp;
        for (int i = 0; i <= 3; i++) begin
            req_valid_i = (i == 0);
            req_op_i    = OP_INV_SET;
            req_addr_i  = mk_addr(40'hff, 3'd3);
            req_way_i   = 4'b1001;
            exp = {1'b0, i == 1, i == 2};
            @(negedge clk);
            n_checks++;
            if ({dir_check_o, dir_inval_o, rsp_valid_o} !== exp) begin
                n_fail++;
                $display("FAIL by_set_c%0d: got chk/inv/rsp %b expected %b", i,
                         {dir_check_o, dir_inval_o, rsp_valid_o}, exp);
            end
            if (i == 1) begin
                n_checks++;
                if (dir_inval_set_o !== 3'd3 || dir_inval_way_o !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL by_set_target: got set %0d way %b expected set 3 way 1001",
                             dir_inval_set_o, dir_inval_way_o);
                end
            end
            tick();
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
    endtask

    task automatic test_inval_all(input logic toggle_ready);
        int inv_base, rsp_base;
        logic done, ok;
        inv_base = inv_set_q.size();
        rsp_base = rsp_cnt;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            req_valid_i = (i == 0);
            req_op_i    = OP_INV_ALL;
            dir_inval_ready_i = toggle_ready ? i[0] : 1'b1;
            tick();
            if (rsp_cnt != rsp_base) done = 1'b1;
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
        dir_inval_ready_i = 1'b1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL inval_all_timeout: got no rsp expected rsp within 100 cycles");
        end
        tick();
        tick();
        n_checks++;
        if (inv_set_q.size() - inv_base != SETS) begin
            n_fail++;
            $display("FAIL inval_all_count: got %0d invals expected %0d", inv_set_q.size() - inv_base, SETS);
        end else begin
            for (int k = 0; k < SETS; k++) begin
                n_checks++;
                if (inv_set_q[inv_base+k] !== SW'(k) || inv_way_q[inv_base+k] !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL inval_all_set%0d: got set %0d way %b expected set %0d way 1111", k,
                             inv_set_q[inv_base+k], inv_way_q[inv_base+k], k);
                end
            end
            if (!toggle_ready) begin
                ok = 1'b1;
                for (int k = 0; k < SETS; k++)
                    if (inv_cyc_q[inv_base+k] - inv_cyc_q[inv_base] != k) ok = 1'b0;
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL inval_all_back_to_back: got last gap %0d expected %0d",
                             inv_cyc_q[inv_base+SETS-1] - inv_cyc_q[inv_base], SETS - 1);
                end
            end
        end
        n_checks++;
        if (rsp_cnt - rsp_base != 1) begin
            n_fail++;
            $display("FAIL inval_all_rsp: got %0d rsp expected 1", rsp_cnt - rsp_base);
        end
    endtask

    task automatic test_flush_nline();
        int inv_base, fl_base, rsp_base;
        logic done;
        inv_base = inv_set_q.size();
        fl_base  = fl_set_q.size();
        rsp_base = rsp_cnt;
        tb_hit[6]   = 4'b0010;
        tb_dirty[6] = 4'b0011;
        flush_empty_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            req_valid_i = (i == 0);
            req_op_i    = OP_FL_NLINE;
            req_addr_i  = mk_addr(40'hab, 3'd6);
            tick();
            if (inv_set_q.size() != inv_base) done = 1'b1;
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL flush_nline_timeout: got no inval expected one within 50 cycles");
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (rsp_cnt != rsp_base || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nline_hold: got rsp %0d ready %b expected rsp 0 ready 0",
                     rsp_cnt - rsp_base, req_ready_o);
        end
        flush_empty_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rsp_cnt - rsp_base != 1) begin
            n_fail++;
            $display("FAIL flush_nline_rsp: got %0d rsp expected 1", rsp_cnt - rsp_base);
        end
        n_checks++;
        if (fl_set_q.size() - fl_base != 1 || fl_set_q[fl_base] !== 3'd6 || fl_way_q[fl_base] !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_nline_flush: got %0d flushes first way %b expected 1 flush set 6 way 0010",
                     fl_set_q.size() - fl_base, fl_way_q[fl_base]);
        end
        n_checks++;
        if (inv_set_q.size() - inv_base != 1 || inv_set_q[inv_base] !== 3'd6 || inv_way_q[inv_base] !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_nline_inval: got set %0d way %b expected set 6 way 0010",
                     inv_set_q[inv_base], inv_way_q[inv_base]);
        end
        tb_hit[6] = '0;
        tb_dirty[6] = '0;
    endtask

    task automatic test_flush_all();
        int inv_base, fl_base, rsp_base, chk_base;
        logic done, ok;
        inv_base = inv_set_q.size();
        fl_base  = fl_set_q.size();
        rsp_base = rsp_cnt;
        chk_base = chk_cnt;
        tb_dirty[2] = 4'b1010;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            req_valid_i = (i == 0);
            req_op_i    = OP_FL_ALL;
            flush_ready_i = i[1];
            tick();
            if (rsp_cnt != rsp_base) done = 1'b1;
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
        flush_ready_i = 1'b1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL flush_all_timeout: got no rsp expected rsp within 200 cycles");
        end
        tick();
        tick();
        n_checks++;
        if (fl_set_q.size() - fl_base != 2) begin
            n_fail++;
            $display("FAIL flush_all_flush_count: got %0d expected 2", fl_set_q.size() - fl_base);
        end else begin
            n_checks++;
            if (fl_set_q[fl_base] !== 3'd2 || fl_way_q[fl_base] !== 4'b0010 ||
                fl_set_q[fl_base+1] !== 3'd2 || fl_way_q[fl_base+1] !== 4'b1000) begin
                n_fail++;
                $display("FAIL flush_all_flushes: got (%0d,%b) (%0d,%b) expected (2,0010) (2,1000)",
                         fl_set_q[fl_base], fl_way_q[fl_base], fl_set_q[fl_base+1], fl_way_q[fl_base+1]);
            end
        end
        ok = (inv_set_q.size() - inv_base == SETS);
        if (ok)
            for (int k = 0; k < SETS; k++)
                if (inv_set_q[inv_base+k] !== SW'(k) || inv_way_q[inv_base+k] !== 4'b1111) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_all_invals: got %0d invals expected %0d in set order with way 1111",
                     inv_set_q.size() - inv_base, SETS);
        end
        n_checks++;
        if (chk_cnt - chk_base != SETS) begin
            n_fail++;
            $display("FAIL flush_all_checks: got %0d expected %0d", chk_cnt - chk_base, SETS);
        end
        n_checks++;
        if (rsp_cnt - rsp_base != 1) begin
            n_fail++;
            $display("FAIL flush_all_rsp: got %0d expected 1", rsp_cnt - rsp_base);
        end
        tb_dirty[2] = '0;
    endtask

    task automatic test_illegal_op();
        int rsp_base;
        rsp_base = rsp_cnt;
        for (int i = 0; i < 5; i++) begin
            req_valid_i = 1'b1;
            req_op_i    = (i < 3) ? hpdcache_cmoh_op_t'(6'b110000) : hpdcache_cmoh_op_t'(6'b000000);
            @(negedge clk);
            n_checks++;
            if ({req_ready_o, wbuf_flush_all_o, dir_check_o, dir_inval_o} !== 4'b1000) begin
                n_fail++;
                $display("FAIL illegal_op_c%0d: got ready/fa/chk/inv %b expected 1000", i,
                         {req_ready_o, wbuf_flush_all_o, dir_check_o, dir_inval_o});
            end
            tick();
        end
        req_valid_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (rsp_cnt != rsp_base) begin
            n_fail++;
            $display("FAIL illegal_op_rsp: got %0d expected 0", rsp_cnt - rsp_base);
        end
    endtask

    task automatic test_reset_mid_flush();
        int rsp_base;
        logic seen;
        rsp_base = rsp_cnt;
        tb_hit[4]   = 4'b0001;
        tb_dirty[4] = 4'b0001;
        flush_ready_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            req_valid_i = (i == 0);
            req_op_i    = OP_FL_NLINE;
            req_addr_i  = mk_addr(40'h5, 3'd4);
            tick();
            if (flush_valid_o === 1'b1) seen = 1'b1;
        end
        req_valid_i = 1'b0;
        req_op_i = '0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_flush_timeout: got no flush_valid expected one within 20 cycles");
        end
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flush_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_in_reset: got %b expected 0", flush_valid_o);
        end
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({flush_valid_o, req_ready_o, rsp_valid_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_flush_after: got flush/ready/rsp %b expected 010",
                     {flush_valid_o, req_ready_o, rsp_valid_o});
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (rsp_cnt != rsp_base) begin
            n_fail++;
            $display("FAIL reset_flush_rsp: got %0d expected 0", rsp_cnt - rsp_base);
        end
        flush_ready_i = 1'b1;
        tb_hit[4] = '0;
        tb_dirty[4] = '0;
    endtask

    initial begin
        rst_i = 1'b1;
        wbuf_empty_i = 1'b1;
        mshr_empty_i = 1'b1;
        rtab_empty_i = 1'b1;
        ctrl_empty_i = 1'b1;
        flush_empty_i = 1'b1;
        req_valid_i = 1'b0;
        req_op_i = '0;
        req_addr_i = '0;
        req_way_i = '0;
        dir_inval_ready_i = 1'b1;
        flush_ready_i = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            tb_hit[s] = '0;
            tb_dirty[s] = '0;
        end

        test_reset();
        test_fence_immediate();
        test_fence_wait();
        test_inval_nline_drain();
        test_nline_miss();
        test_inval_by_set();
        test_inval_all(1'b1);
        test_inval_all(1'b0);
        test_flush_nline();
        test_flush_all();
        test_illegal_op();
        test_reset_mid_flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
